// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: debounced level, press/release/long-press pulses per key.
// Auto-repeat pulses are built only when KEY_DEBOUNCE_MULTI_REPEAT_EN is defined.
module key_debounce_multi #(
   parameter int unsigned NUM_KEYS    = 32'd4,
   parameter int unsigned CLK_FREQ_HZ = 32'd50_000_000,
   parameter int unsigned DEBOUNCE_MS = 32'd20,
   parameter int unsigned LONG_MS     = 32'd1000,
   parameter int unsigned REPEAT_MS   = 32'd200,
   parameter int unsigned ACTIVE_LOW  = 32'd1
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic [NUM_KEYS-1:0] key_in,
   output logic [NUM_KEYS-1:0] key_state,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_long,
   output logic [NUM_KEYS-1:0] key_repeat
);

   localparam int unsigned DB_CYC   = CLK_FREQ_HZ / 32'd1000 * DEBOUNCE_MS;
   localparam int unsigned LONG_CYC = CLK_FREQ_HZ / 32'd1000 * LONG_MS;
   localparam int unsigned REP_CYC  = CLK_FREQ_HZ / 32'd1000 * REPEAT_MS;
   localparam int unsigned MAX_DL   = (DB_CYC > LONG_CYC) ? DB_CYC : LONG_CYC;
   localparam int unsigned MAX_CYC  = (MAX_DL > REP_CYC) ? MAX_DL : REP_CYC;
   localparam int unsigned CW       = $clog2(MAX_CYC) + 32'd1;

   localparam logic [CW-1:0] ZERO   = CW'(0);
   localparam logic [CW-1:0] ONE    = CW'(1);
   localparam logic [CW-1:0] DB_C   = CW'(DB_CYC);
   localparam logic [CW-1:0] LONG_C = CW'(LONG_CYC);
`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
   localparam logic [CW-1:0] REP_C  = CW'(REP_CYC);
`endif

   // Pin level that means "released", so a held key after reset still needs a full debounce
   localparam logic [NUM_KEYS-1:0] REL_LVL = (ACTIVE_LOW != 32'd0) ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_DB   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } state_e;

   logic [NUM_KEYS-1:0] sync1_q;
   logic [NUM_KEYS-1:0] sync2_q;
   logic [NUM_KEYS-1:0] pressed_s;

   // Two-flop synchronizer on the raw pins
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1_q <= REL_LVL;
         sync2_q <= REL_LVL;
      end else begin
         sync1_q <= key_in;
         sync2_q <= sync1_q;
      end
   end

   assign pressed_s = (ACTIVE_LOW != 32'd0) ? ~sync2_q : sync2_q;

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
      state_e        state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic [CW-1:0] hold_q, hold_d, hold_inc_s;
      logic          level_q, level_d;
      logic          press_q, press_d;
      logic          release_q, release_d;
      logic          long_q, long_d;
      logic          holding_s;

      assign holding_s  = (state_q == HELD) || (state_q == RELEASE_DB);
      assign hold_inc_s = hold_q + ONE;

      // Debounce FSM: debounce count runs only in the two *_DB states
      always_comb begin
         state_d   = state_q;
         cnt_d     = cnt_q;
         level_d   = level_q;
         press_d   = 1'b0;
         release_d = 1'b0;
         case (state_q)
            IDLE: begin
               if (pressed_s[g]) begin
                  state_d = PRESS_DB;
                  cnt_d   = DB_C;
               end else begin
                  cnt_d   = ZERO;
               end
            end
            PRESS_DB: begin
               if (!pressed_s[g]) begin
                  state_d = IDLE;
                  cnt_d   = ZERO;
               end else if (cnt_q <= ONE) begin
                  state_d = HELD;
                  cnt_d   = ZERO;
                  press_d = 1'b1;
                  level_d = 1'b1;
               end else begin
                  cnt_d   = cnt_q - ONE;
               end
            end
            HELD: begin
               if (!pressed_s[g]) begin
                  state_d = RELEASE_DB;
                  cnt_d   = DB_C;
               end else begin
                  cnt_d   = ZERO;
               end
            end
            RELEASE_DB: begin
               if (pressed_s[g]) begin
                  state_d = HELD;
                  cnt_d   = ZERO;
               end else if (cnt_q <= ONE) begin
                  state_d   = IDLE;
                  cnt_d     = ZERO;
                  release_d = 1'b1;
                  level_d   = 1'b0;
               end else begin
                  cnt_d     = cnt_q - ONE;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = ZERO;
               level_d = 1'b0;
            end
         endcase
      end

      // Hold counter spans HELD and RELEASE_DB and saturates at LONG_CYC
      always_comb begin
         hold_d = ZERO;
         long_d = 1'b0;
         if (holding_s) begin
            if (hold_q != LONG_C) begin
               hold_d = hold_inc_s;
               long_d = (hold_inc_s == LONG_C);
            end else begin
               hold_d = hold_q;
            end
         end else begin
            hold_d = ZERO;
         end
      end

      // Channel state and registered event outputs
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
         if (!sys_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= ZERO;
            hold_q    <= ZERO;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
         end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
         end
      end

      assign key_state[g]   = level_q;
      assign key_press[g]   = press_q;
      assign key_release[g] = release_q;
      assign key_long[g]    = long_q;

`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
      logic [CW-1:0] rep_q, rep_d, rep_inc_s;
      logic          rep_pulse_d, repeat_q;

      assign rep_inc_s = rep_q + ONE;

      // Repeat period counts only after the long event; the release cycle itself never repeats
      always_comb begin
         rep_d       = ZERO;
         rep_pulse_d = 1'b0;
         if (holding_s && (hold_q == LONG_C) && !release_d) begin
            if (rep_inc_s == REP_C) begin
               rep_d       = ZERO;
               rep_pulse_d = 1'b1;
            end else begin
               rep_d       = rep_inc_s;
            end
         end else begin
            rep_d = ZERO;
         end
      end

      // Repeat counter and registered repeat pulse
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
         if (!sys_rst_n) begin
            rep_q    <= ZERO;
            repeat_q <= 1'b0;
         end else begin
            rep_q    <= rep_d;
            repeat_q <= rep_pulse_d;
         end
      end

      assign key_repeat[g] = repeat_q;
`else
      assign key_repeat[g] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Self-checking bench for key_debounce_multi: directed scenarios plus randomized key
// activity compared against a run-length reference model.
module tb_key_debounce_multi;

   localparam int NK   = 4;
   localparam int DB   = 20;
   localparam int LONG = 100;
   localparam int REP  = 50;
`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic          sys_clk = 1'b0;
   logic          sys_rst_n;
   logic [NK-1:0] key_in;
   logic [NK-1:0] key_state, key_press, key_release, key_long, key_repeat;

   int checks   = 0;
   int failures = 0;

   key_debounce_multi #(
      .NUM_KEYS(NK), .CLK_FREQ_HZ(1000), .DEBOUNCE_MS(20),
      .LONG_MS(100), .REPEAT_MS(50), .ACTIVE_LOW(1)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
      .key_state(key_state), .key_press(key_press), .key_release(key_release),
      .key_long(key_long), .key_repeat(key_repeat)
   );

   always #5 sys_clk = ~sys_clk;

   // Reference model: an event fires when the synchronized level has disagreed with the
   // debounced level for DB+1 consecutive samples; hold time counts edges since the press.
   logic [NK-1:0] ms1, ms2;
   logic [NK-1:0] e_state, e_press, e_rel, e_long, e_rep;
   int  run_m [NK];
   int  hold_m[NK];
   bit  lvl_m [NK];

   always @(posedge sys_clk or negedge sys_rst_n) begin
      logic [NK-1:0] p_v, r_v, l_v, t_v, s_v;
      bit pr, was_held;
      if (!sys_rst_n) begin
         ms1 = '1; ms2 = '1;
         for (int i = 0; i < NK; i++) begin run_m[i] = 0; hold_m[i] = 0; lvl_m[i] = 1'b0; end
         e_state <= '0; e_press <= '0; e_rel <= '0; e_long <= '0; e_rep <= '0;
      end else begin
         p_v = '0; r_v = '0; l_v = '0; t_v = '0; s_v = '0;
         for (int i = 0; i < NK; i++) begin
            pr = ~ms2[i];
            was_held = lvl_m[i];
            if (pr != lvl_m[i]) begin
               run_m[i]++;
               if (run_m[i] == DB + 1) begin
                  lvl_m[i] = pr;
                  run_m[i] = 0;
                  if (pr) begin p_v[i] = 1'b1; hold_m[i] = 0; end
                  else r_v[i] = 1'b1;
               end
            end else begin
               run_m[i] = 0;
            end
            if (was_held) begin
               hold_m[i]++;
               if (hold_m[i] == LONG) l_v[i] = 1'b1;
               else if (REP_EN && !r_v[i] && hold_m[i] > LONG && ((hold_m[i] - LONG) % REP) == 0)
                  t_v[i] = 1'b1;
            end
            s_v[i] = lvl_m[i];
         end
         ms2 = ms1; ms1 = key_in;
         e_state <= s_v; e_press <= p_v; e_rel <= r_v; e_long <= l_v; e_rep <= t_v;
      end
   end

   task automatic step();
      @(posedge sys_clk);
      @(negedge sys_clk);
   endtask

   function automatic logic [NK-1:0] pick(input int kind);
      case (kind)
         0:       return key_press;
         1:       return key_release;
         2:       return key_long;
         default: return key_repeat;
      endcase
   endfunction

   // Edges until the selected pulse appears on channel ch, or -1 when the budget runs out
   task automatic wait_pulse(input int ch, input int kind, input int budget, output int cyc);
      logic [NK-1:0] v;
      cyc = -1;
      for (int k = 1; k <= budget; k++) begin
         step();
         v = pick(kind);
         if (v[ch] === 1'b1) begin cyc = k; break; end
      end
   endtask

   task automatic settle();
      key_in = '1;
      repeat (40) step();
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      key_in = '0;
      repeat (3) step();
      checks++; if (key_state !== 4'b0) begin failures++; $display("FAIL reset_state: got %b want 0000", key_state); end
      checks++; if (key_press !== 4'b0) begin failures++; $display("FAIL reset_press: got %b want 0000", key_press); end
      checks++; if (key_release !== 4'b0) begin failures++; $display("FAIL reset_release: got %b want 0000", key_release); end
      checks++; if (key_long !== 4'b0) begin failures++; $display("FAIL reset_long: got %b want 0000", key_long); end
      checks++; if (key_repeat !== 4'b0) begin failures++; $display("FAIL reset_repeat: got %b want 0000", key_repeat); end
      key_in = '1;
      step();
      sys_rst_n = 1'b1;
      repeat (30) step();
      checks++; if ((key_state | key_release) !== 4'b0) begin failures++; $display("FAIL reset_exit_quiet: got %b want 0000", key_state | key_release); end
   endtask

   task automatic test_clean_press();
      int c;
      key_in[0] = 1'b0;
      wait_pulse(0, 0, 40, c);
      checks++; if (c !== 23) begin failures++; $display("FAIL press_latency: got %0d want 23", c); end
      checks++; if (key_state[0] !== 1'b1) begin failures++; $display("FAIL press_state: got %b want 1", key_state[0]); end
      step();
      checks++; if (key_press[0] !== 1'b0) begin failures++; $display("FAIL press_width: got %b want 0", key_press[0]); end
      repeat (36) step();
      key_in[0] = 1'b1;
      wait_pulse(0, 1, 40, c);
      checks++; if (c !== 23) begin failures++; $display("FAIL release_latency: got %0d want 23", c); end
      checks++; if (key_state[0] !== 1'b0) begin failures++; $display("FAIL release_state: got %b want 0", key_state[0]); end
   endtask

   task automatic test_bounce();
      int lens[4] = '{5, 3, 7, 4};
      int ev = 0, st = 0;
      for (int s = 0; s < 4; s++) begin
         key_in[1] = (s % 2 == 1);
         repeat (lens[s]) begin
            step();
            if (key_press[1] | key_release[1] | key_long[1] | key_repeat[1]) ev++;
            if (key_state[1]) st++;
         end
      end
      key_in[1] = 1'b1;
      repeat (40) begin
         step();
         if (key_press[1] | key_release[1] | key_long[1] | key_repeat[1]) ev++;
         if (key_state[1]) st++;
      end
      checks++; if (ev !== 0) begin failures++; $display("FAIL bounce_events: got %0d want 0", ev); end
      checks++; if (st !== 0) begin failures++; $display("FAIL bounce_state: got %0d want 0", st); end
   endtask

   task automatic test_long_repeat();
      int press_at = -1, rel_at = -1, long_n = 0, long_at = -1;
      int reps[$];
      int exp_rep[$];
      key_in[2] = 1'b0;
      for (int k = 1; k <= 345; k++) begin
         step();
         if (key_press[2] && press_at < 0) press_at = k;
         if (key_release[2] && rel_at < 0) rel_at = k;
         if (key_long[2]) begin long_n++; long_at = k; end
         if (key_repeat[2]) reps.push_back(k);
         if (k == 300) key_in[2] = 1'b1;
      end
      if (REP_EN) exp_rep = {23 + 150, 23 + 200, 23 + 250};
      checks++; if (press_at !== 23) begin failures++; $display("FAIL long_press_at: got %0d want 23", press_at); end
      checks++; if (long_n !== 1) begin failures++; $display("FAIL long_count: got %0d want 1", long_n); end
      checks++; if (long_at !== 123) begin failures++; $display("FAIL long_at: got %0d want 123", long_at); end
      checks++; if (reps.size() !== exp_rep.size()) begin failures++; $display("FAIL repeat_count: got %0d want %0d", reps.size(), exp_rep.size()); end
      for (int i = 0; i < exp_rep.size() && i < reps.size(); i++) begin
         checks++; if (reps[i] !== exp_rep[i]) begin failures++; $display("FAIL repeat_at[%0d]: got %0d want %0d", i, reps[i], exp_rep[i]); end
      end
      checks++; if (rel_at !== 323) begin failures++; $display("FAIL long_release_at: got %0d want 323", rel_at); end
   endtask

   task automatic test_simultaneous();
      int c;
      key_in[0] = 1'b0; key_in[3] = 1'b0;
      wait_pulse(0, 0, 40, c);
      checks++; if (c !== 23) begin failures++; $display("FAIL simul_latency: got %0d want 23", c); end
      checks++; if (key_press !== 4'b1001) begin failures++; $display("FAIL simul_press: got %b want 1001", key_press); end
      repeat (10) step();
      key_in[0] = 1'b1; key_in[3] = 1'b1;
      wait_pulse(3, 1, 40, c);
      checks++; if (key_release !== 4'b1001) begin failures++; $display("FAIL simul_release: got %b want 1001", key_release); end
   endtask

   task automatic test_reset_mid();
      int c, ev = 0;
      key_in[1] = 1'b0;
      repeat (15) begin step(); if (key_press | key_release | key_state) ev++; end
      sys_rst_n = 1'b0;
      repeat (3) begin step(); if (key_press | key_release | key_state | key_long | key_repeat) ev++; end
      sys_rst_n = 1'b1;
      checks++; if (ev !== 0) begin failures++; $display("FAIL rstmid_quiet: got %0d want 0", ev); end
      wait_pulse(1, 0, 40, c);
      checks++; if (c !== 23) begin failures++; $display("FAIL rstmid_press: got %0d want 23", c); end
      checks++; if (key_release !== 4'b0) begin failures++; $display("FAIL rstmid_release: got %b want 0000", key_release); end
      key_in[1] = 1'b1;
      wait_pulse(1, 1, 40, c);
      checks++; if (c !== 23) begin failures++; $display("FAIL rstmid_rel_latency: got %0d want 23", c); end
   endtask

   task automatic test_glitch();
      int c, rel = 0, low = 0;
      key_in[2] = 1'b0;
      wait_pulse(2, 0, 40, c);
      checks++; if (c !== 23) begin failures++; $display("FAIL glitch_press: got %0d want 23", c); end
      repeat (30) step();
      key_in[2] = 1'b1;
      repeat (10) begin step(); if (key_release[2]) rel++; if (!key_state[2]) low++; end
      key_in[2] = 1'b0;
      repeat (40) begin step(); if (key_release[2]) rel++; if (!key_state[2]) low++; end
      checks++; if (rel !== 0) begin failures++; $display("FAIL glitch_release: got %0d want 0", rel); end
      checks++; if (low !== 0) begin failures++; $display("FAIL glitch_state: got %0d low samples want 0", low); end
      key_in[2] = 1'b1;
      wait_pulse(2, 1, 40, c);
      checks++; if (c !== 23) begin failures++; $display("FAIL glitch_rel_latency: got %0d want 23", c); end
   endtask

   task automatic test_random();
      int rem[NK];
      for (int i = 0; i < NK; i++) rem[i] = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         checks++; if (key_state !== e_state) begin failures++; $display("FAIL rnd_state @%0d: got %b want %b", cyc, key_state, e_state); end
         checks++; if (key_press !== e_press) begin failures++; $display("FAIL rnd_press @%0d: got %b want %b", cyc, key_press, e_press); end
         checks++; if (key_release !== e_rel) begin failures++; $display("FAIL rnd_release @%0d: got %b want %b", cyc, key_release, e_rel); end
         checks++; if (key_long !== e_long) begin failures++; $display("FAIL rnd_long @%0d: got %b want %b", cyc, key_long, e_long); end
         checks++; if (key_repeat !== e_rep) begin failures++; $display("FAIL rnd_repeat @%0d: got %b want %b", cyc, key_repeat, e_rep); end
         for (int i = 0; i < NK; i++) begin
            if (rem[i] == 0) begin
               key_in[i] = ~key_in[i];
               rem[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 24) : $urandom_range(18, 260);
            end
            rem[i]--;
         end
         sys_rst_n = !(cyc >= 2000 && cyc < 2003);
         step();
      end
   endtask

   initial begin
      sys_rst_n = 1'b0;
      key_in = '1;
      test_reset();
      settle();
      test_clean_press();
      settle();
      test_bounce();
      settle();
      test_long_repeat();
      settle();
      test_simultaneous();
      settle();
      test_reset_mid();
      settle();
      test_glitch();
      settle();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/key_debounce_multi.md
KEY_DEBOUNCE_MULTI -- requirements
Module: key_debounce_multi

Interface
REQ-001 The block SHALL have parameter NUM_KEYS, default 4, giving the number of independent key channels (1..16).
REQ-002 The block SHALL have parameter CLK_FREQ_HZ, default 50_000_000, giving the sys_clk frequency.
REQ-003 The block SHALL have parameter DEBOUNCE_MS, default 20, giving the required stable time.
REQ-004 The block SHALL have parameter LONG_MS, default 1000, giving the hold time before a long-press event.
REQ-005 The block SHALL have parameter REPEAT_MS, default 200, giving the auto-repeat period.
REQ-006 The block SHALL have parameter ACTIVE_LOW, default 1, where 1 means a pressed key reads 0.
REQ-007 The block SHALL have port sys_clk  input  1  system clock.
REQ-008 The block SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-009 The block SHALL have port key_in  input  NUM_KEYS  raw asynchronous key pins.
REQ-010 The block SHALL have port key_state  output  NUM_KEYS  debounced pressed level, 1 = pressed.
REQ-011 The block SHALL have port key_press  output  NUM_KEYS  one-cycle pulse on a debounced press.
REQ-012 The block SHALL have port key_release  output  NUM_KEYS  one-cycle pulse on a debounced release.
REQ-013 The block SHALL have port key_long  output  NUM_KEYS  one-cycle pulse once per hold reaching LONG_MS.
REQ-014 The block SHALL have port key_repeat  output  NUM_KEYS  one-cycle auto-repeat pulse.

Function
REQ-015 Each channel SHALL pass key_in through a 2-flop synchronizer, then normalise the result to pressed = 1 according to ACTIVE_LOW.
REQ-016 Derived cycle counts SHALL be computed at elaboration: DB_CYC = CLK_FREQ_HZ/1000*DEBOUNCE_MS, LONG_CYC and REP_CYC computed likewise.
REQ-017 Counter widths SHALL be $clog2 of the largest count plus 1, with no truncation.
REQ-018 Each channel SHALL run an independent FSM with states IDLE, PRESS_DB, HELD and RELEASE_DB.
REQ-019 IDLE SHALL go to PRESS_DB when the synchronized level is pressed, loading the counter with DB_CYC.
REQ-020 In PRESS_DB, a return to released SHALL send the FSM back to IDLE with no event.
REQ-021 In PRESS_DB, DB_CYC consecutive pressed samples SHALL move the FSM to HELD, pulse key_press and set key_state.
REQ-022 In HELD, a released sample SHALL move the FSM to RELEASE_DB and reload the debounce counter, while the hold counter keeps counting.
REQ-023 In RELEASE_DB, a pressed sample SHALL return the FSM to HELD with no event, so the glitch is absorbed.
REQ-024 In RELEASE_DB, DB_CYC consecutive released samples SHALL move the FSM to IDLE, pulse key_release and clear key_state.
REQ-025 Latency: key_press/key_release SHALL first go high exactly DB_CYC+3 sys_clk edges after a clean raw edge (2 sync + DB_CYC + 1 output register).
REQ-026 The hold counter SHALL start on entry to HELD; key_long SHALL pulse once when it reaches LONG_CYC and SHALL saturate thereafter.
REQ-027 All pulse outputs SHALL be registered and high for exactly one cycle per event.
REQ-028 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-029 If key_long and key_release would coincide, both SHALL be asserted in that cycle.
REQ-030 A raw pulse shorter than DB_CYC cycles SHALL produce no event and no key_state change.

Reset
REQ-031 While sys_rst_n = 0, all FSMs SHALL be in IDLE, all counters 0, and key_state, key_press, key_release, key_long and key_repeat all 0.
REQ-032 The synchronizer flops SHALL reset to the released level, so a key already held at reset release yields key_press after DB_CYC+3 cycles and never a spurious key_release.
REQ-033 Reset asserted mid-debounce or mid-hold SHALL abort the channel silently, with no pulse during or after reset.

Configuration
REQ-034 Macro KEY_DEBOUNCE_MULTI_REPEAT_EN SHALL control auto-repeat; when defined, key_repeat SHALL pulse every REP_CYC cycles after key_long while the FSM remains in HELD/RELEASE_DB, stopping on key_release.
REQ-035 When KEY_DEBOUNCE_MULTI_REPEAT_EN is undefined, key_repeat SHALL be constant 0 and the repeat counter logic SHALL not be synthesised.

Verification (bench parameters: CLK_FREQ_HZ=1000, DEBOUNCE_MS=20, LONG_MS=100, REPEAT_MS=50, NUM_KEYS=4, ACTIVE_LOW=1)
REQ-036 Stimulus: key_in[0] is driven low cleanly and held for 60 cycles, then released. Required response: key_press[0] pulses 23 cycles after the falling edge, key_state[0] = 1, and key_release[0] pulses 23 cycles after the rising edge.
REQ-037 Stimulus: key_in[1] bounces as 5 low, 3 high, 7 low, 4 high, then returns high. Required response: no pulses and key_state[1] stays 0.
REQ-038 Stimulus: key_in[2] is held low for 300 cycles. Required response: key_long[2] pulses once at hold count 100; with the macro, key_repeat[2] pulses at hold counts 150, 200 and 250; without it, key_repeat stays 0.
REQ-039 Stimulus: key_in[0] and key_in[3] fall in the same cycle. Required response: key_press[0] and key_press[3] are asserted in the same cycle.
REQ-040 Stimulus: sys_rst_n is pulsed low while key_in[1] is held (15 cycles into the hold). Required response: no pulse; after reset is released, key_press[1] pulses 23 cycles later.
REQ-041 Stimulus: during HELD, key_in[2] has a 10-cycle high glitch. Required response: no key_release and key_state[2] stays 1.
